// File: rtl/nihilist_stream_encryptor.sv
// Nihilist cipher stream encryptor: one ASCII character in, one row*10+col sum out, keyed by "NEDELCU".
// Optional macro NIHILIST_J_MERGE_EN folds 'J' onto 'I'; without it 'J' is reported as an invalid character.
module nihilist_stream_encryptor #(
    parameter int SEC_LEN = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_err,
    input  logic       out_ready
);

    localparam int KW = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;
    localparam logic [7:0] KEY [7] = '{"N", "E", "D", "E", "L", "C", "U"};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [KW-1:0] kidx;
    logic [7:0]    char_r;
    logic          last_r;
    logic          rdy_en;
    logic          accept;
    logic          handshake;
    logic [8:0]    char_pos;
    logic [8:0]    key_pos;

    // Returns {valid, row*10+col}; valid=0 for anything outside the 5x5 square.
    function automatic logic [8:0] table_pos(input logic [7:0] c);
        case (c)
            "R": return {1'b1, 8'd11};
            "A": return {1'b1, 8'd12};
            "E": return {1'b1, 8'd13};
            "S": return {1'b1, 8'd14};
            "B": return {1'b1, 8'd15};
            "C": return {1'b1, 8'd21};
            "D": return {1'b1, 8'd22};
            "F": return {1'b1, 8'd23};
            "G": return {1'b1, 8'd24};
            "H": return {1'b1, 8'd25};
            "I": return {1'b1, 8'd31};
`ifdef NIHILIST_J_MERGE_EN
            "J": return {1'b1, 8'd31};
`endif
            "K": return {1'b1, 8'd32};
            "L": return {1'b1, 8'd33};
            "M": return {1'b1, 8'd34};
            "N": return {1'b1, 8'd35};
            "O": return {1'b1, 8'd41};
            "P": return {1'b1, 8'd42};
            "Q": return {1'b1, 8'd43};
            "T": return {1'b1, 8'd44};
            "U": return {1'b1, 8'd45};
            "V": return {1'b1, 8'd51};
            "W": return {1'b1, 8'd52};
            "X": return {1'b1, 8'd53};
            "Y": return {1'b1, 8'd54};
            "Z": return {1'b1, 8'd55};
            default: return 9'd0;
        endcase
    endfunction

    // rdy_en keeps in_ready low during reset and until the first clock edge after it.
    assign in_ready  = (state == IDLE) && rdy_en;
    assign out_valid = (state == OUT);
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;
    assign char_pos  = table_pos(char_r);
    assign key_pos   = table_pos(KEY[kidx]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en   <= 1'b0;
            kidx     <= '0;
            char_r   <= 8'd0;
            last_r   <= 1'b0;
            out_data <= 8'd0;
            out_err  <= 1'b0;
            out_last <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                char_r <= in_data;
                last_r <= in_last;
            end
            if (state == CALC) begin
                out_data <= char_pos[8] ? (char_pos[7:0] + key_pos[7:0]) : 8'd0;
                out_err  <= ~char_pos[8];
                out_last <= last_r;
            end
            // The key restarts at the next message, otherwise it walks and wraps.
            if (handshake) begin
                if (out_last || (kidx == KW'(SEC_LEN - 1))) begin
                    kidx <= '0;
                end else begin
                    kidx <= kidx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nihilist_stream_encryptor.sv
// Scoreboard bench for nihilist_stream_encryptor: directed cipher vectors, stall/reset handling and random traffic
// checked against a string-based Polybius model. Honours NIHILIST_J_MERGE_EN when defined.
module tb_nihilist_stream_encryptor;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_err;
    logic       out_ready;

    int checks   = 0;
    int failures = 0;
    int ready_mode = 0;
    int model_kidx = 0;
    logic [9:0] exp_q [$];

    nihilist_stream_encryptor #(.SEC_LEN(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_err   (out_err),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // out_ready changes just after each rising edge so it is stable when sampled on the falling edge.
    initial out_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int square_index(input byte c);
        string tbl = "RAESBCDFGHIKLMNOPQTUVWXYZ";
        for (int i = 0; i < 25; i++) begin
            if (tbl[i] == c) return i;
        end
        return -1;
    endfunction

    // Expected {last, err, data} for character c encrypted with key letter k.
    function automatic logic [9:0] model_beat(input byte c, input int k, input logic last);
        string key = "NEDELCU";
        byte   ch  = c;
        int    ci;
        int    ki;
        int    sum;
`ifdef NIHILIST_J_MERGE_EN
        if (ch == "J") ch = "I";
`endif
        ci = square_index(ch);
        if (ci < 0) return {last, 1'b1, 8'd0};
        ki  = square_index(key[k]);
        sum = (ci / 5 + 1) * 10 + (ci % 5 + 1) + (ki / 5 + 1) * 10 + (ki % 5 + 1);
        return {last, 1'b0, 8'(sum)};
    endfunction

    // Drives one character starting at a falling edge and queues the given expected beat.
    task automatic apply_stimulus(input byte ch, input logic last, input logic [9:0] exp);
        int waitc = 0;
        in_valid = 1'b1;
        in_data  = ch;
        in_last  = last;
        while (!in_ready && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            check_output("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(exp);
        model_kidx = last ? 0 : (model_kidx + 1) % 7;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_model(input byte ch, input logic last);
        apply_stimulus(ch, last, model_beat(ch, model_kidx, last));
    endtask

    task automatic send_exp(input byte ch, input logic last, input int data, input logic err);
        apply_stimulus(ch, last, {last, err, 8'(data)});
    endtask

    task automatic wait_drain();
        int waitc = 0;
        while (exp_q.size() != 0 && waitc < 2000) begin
            @(negedge clk);
            waitc++;
        end
        check_output("drain_left", exp_q.size(), 0);
    endtask

    // Monitor: pops on every output handshake and checks that stalled beats hold still.
    logic       stalled = 1'b0;
    logic [9:0] held;
    always @(negedge clk) begin
        if (rst || !out_valid) begin
            stalled = 1'b0;
        end else begin
            if (stalled) check_output("stall_hold", int'({out_last, out_err, out_data}), int'(held));
            if (out_ready) begin
                stalled = 1'b0;
                if (exp_q.size() == 0) begin
                    check_output("unexpected_beat", int'(out_data), -1);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    check_output("beat_data", int'(out_data), int'(e[7:0]));
                    check_output("beat_err", int'(out_err), int'(e[8]));
                    check_output("beat_last", int'(out_last), int'(e[9]));
                end
            end else begin
                stalled = 1'b1;
                held    = {out_last, out_err, out_data};
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_last  = 1'b0;
        #12;
        check_output("reset_in_ready", int'(in_ready), 0);
        check_output("reset_out_valid", int'(out_valid), 0);
        check_output("reset_out_data", int'(out_data), 0);
        check_output("reset_out_err", int'(out_err), 0);
        check_output("reset_out_last", int'(out_last), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("ready_before_edge", int'(in_ready), 0);
        @(negedge clk);
        check_output("ready_after_edge", int'(in_ready), 1);

        // "HELLO"
        send_exp("H", 1'b0, 60, 1'b0);
        send_exp("E", 1'b0, 26, 1'b0);
        send_exp("L", 1'b0, 55, 1'b0);
        send_exp("L", 1'b0, 46, 1'b0);
        send_exp("O", 1'b1, 74, 1'b0);
        wait_drain();

        // Eight 'A' wrap the key after index 6.
        send_exp("A", 1'b0, 47, 1'b0);
        send_exp("A", 1'b0, 25, 1'b0);
        send_exp("A", 1'b0, 34, 1'b0);
        send_exp("A", 1'b0, 25, 1'b0);
        send_exp("A", 1'b0, 45, 1'b0);
        send_exp("A", 1'b0, 33, 1'b0);
        send_exp("A", 1'b0, 57, 1'b0);
        send_exp("A", 1'b1, 47, 1'b0);
        wait_drain();

        // Largest sum: 'Z' against 'U'.
        for (int i = 0; i < 6; i++) send_model("A", 1'b0);
        send_exp("Z", 1'b1, 100, 1'b0);

        // Invalid character still consumes a key letter.
        send_exp("a", 1'b0, 0, 1'b1);
        send_exp("E", 1'b1, 26, 1'b0);

`ifdef NIHILIST_J_MERGE_EN
        send_exp("J", 1'b1, 66, 1'b0);
`else
        send_exp("J", 1'b1, 0, 1'b1);
`endif
        wait_drain();

        // Hold a beat for five cycles, then reset it away.
        ready_mode = 1;
        @(posedge clk);
        @(negedge clk);
        send_model("A", 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("stall_out_valid", int'(out_valid), 1);
            check_output("stall_in_ready", int'(in_ready), 0);
        end
        #2;
        rst = 1'b1;
        #1;
        check_output("rst_mid_out_valid", int'(out_valid), 0);
        exp_q.delete();
        model_kidx = 0;
        ready_mode = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_exp("H", 1'b1, 60, 1'b0);
        wait_drain();

        // Random traffic with random back-pressure.
        ready_mode = 2;
        for (int n = 0; n < 150; n++) begin
            byte  ch;
            logic last;
            case ($urandom_range(0, 5))
                0:       ch = byte'(8'd97 + 8'($urandom_range(0, 25)));
                1:       ch = byte'(8'd48 + 8'($urandom_range(0, 9)));
                2:       ch = ".";
                default: ch = byte'(8'd65 + 8'($urandom_range(0, 25)));
            endcase
            last = ($urandom_range(0, 5) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_model(ch, last);
        end
        wait_drain();
        ready_mode = 0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
